// File: rtl/sevseg_pkg.sv
// sevseg_pkg: shared constants, hex glyph table and FSM state type for the 7-segment scanner
package sevseg_pkg;

   localparam logic [6:0] SEG_BLANK = 7'h7F;

   // Active-high g..a glyphs; element n is the pattern for hex digit n
   localparam logic [15:0][6:0] HEX_SEG = {
      7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
      7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
   };

   typedef enum logic {ST_BLANK, ST_SHOW} state_t;

endpackage

// File: rtl/sevseg_hex_decode.sv
// sevseg_hex_decode: combinational 4-bit nibble to active-high g..a segment pattern
module sevseg_hex_decode
   import sevseg_pkg::*;
(
   input  logic [3:0] i_nibble,
   output logic [6:0] o_seg
);

   assign o_seg = HEX_SEG[i_nibble];

endmodule

// File: rtl/sevseg_scan_scheduler.sv
// sevseg_scan_scheduler: blanked, tear-free time-multiplexed scan of a shared 7-segment bus
module sevseg_scan_scheduler
   import sevseg_pkg::*;
#(
   parameter int DIGITS       = 4,
   parameter int SCAN_DIV     = 5000,
   parameter int BLANK_CYCLES = 64
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [4*DIGITS-1:0]   wr_data,
   input  logic [DIGITS-1:0]     wr_dp,
   input  logic                  wr_valid,
   output logic                  wr_ready,
   input  logic [DIGITS-1:0]     digit_en,
   output logic [6:0]            seg_n,
   output logic                  dp_n,
   output logic [DIGITS-1:0]     digit_sel,
   output logic                  frame_start
);

   localparam int CW = $clog2(SCAN_DIV);
   localparam int IW = $clog2(DIGITS);
   localparam logic [CW-1:0] CNT_LAST   = CW'(SCAN_DIV - 1);
   localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
   localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);

   state_t              r_state;
   state_t              w_state_nxt;
   logic [CW-1:0]       r_cnt;
   logic [IW-1:0]       r_idx;
   logic                r_en;
   logic [4*DIGITS-1:0] r_act_data;
   logic [DIGITS-1:0]   r_act_dp;
   logic [4*DIGITS-1:0] r_sh_data;
   logic [DIGITS-1:0]   r_sh_dp;
   logic                r_sh_full;
   logic                w_slot_start;
   logic                w_frame_entry;
   logic                w_slot_end;
   logic                w_write;
   logic                w_show;
   logic [3:0]          w_nibble;
   logic [6:0]          w_seg;
   logic [6:0]          w_seg_n_nxt;
   logic                w_dp_n_nxt;
   logic [DIGITS-1:0]   w_sel_nxt;

   // Slot boundaries: the slot counter runs 0..SCAN_DIV-1, blank occupies its first BLANK_CYCLES
   assign w_slot_start  = (r_state == ST_BLANK) && (r_cnt == '0);
   assign w_frame_entry = w_slot_start && (r_idx == '0);
   assign w_slot_end    = (r_state == ST_SHOW) && (r_cnt == CNT_LAST);
   assign w_write       = wr_valid && !r_sh_full;
   assign wr_ready      = !r_sh_full;

   // Next-state: blank hands over to show after BLANK_CYCLES, show returns to blank at slot end
   always_comb begin
      w_state_nxt = (r_state == ST_BLANK) ? ((r_cnt == BLANK_LAST) ? ST_SHOW : ST_BLANK)
                                          : (w_slot_end ? ST_BLANK : ST_SHOW);
   end

   // State register with slot counter, digit index and per-slot enable sampled at slot start
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_BLANK;
         r_cnt   <= '0;
         r_idx   <= '0;
         r_en    <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= (r_cnt == CNT_LAST) ? '0 : r_cnt + 1'b1;
         if (w_slot_end)
            r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
         if (w_slot_start)
            r_en <= digit_en[r_idx];
      end
   end

   // Shadow capture on handshake; a full shadow moves to the active word only at frame entry
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_act_data <= '0;
         r_act_dp   <= '0;
         r_sh_data  <= '0;
         r_sh_dp    <= '0;
         r_sh_full  <= 1'b0;
      end else if (w_frame_entry && r_sh_full) begin
         r_act_data <= r_sh_data;
         r_act_dp   <= r_sh_dp;
         r_sh_full  <= 1'b0;
      end else if (w_write) begin
         r_sh_data  <= wr_data;
         r_sh_dp    <= wr_dp;
         r_sh_full  <= 1'b1;
      end
   end

   assign w_nibble = r_act_data[{r_idx, 2'b00} +: 4];

   sevseg_hex_decode u_decode (
      .i_nibble (w_nibble),
      .o_seg    (w_seg)
   );

   // Output decode: drive the current digit only in an enabled show slot, otherwise dark
   always_comb begin
      w_show      = (r_state == ST_SHOW) && r_en;
      w_sel_nxt   = w_show ? (DIGITS'(1) << r_idx) : '0;
      w_seg_n_nxt = w_show ? ~w_seg : SEG_BLANK;
      w_dp_n_nxt  = !(w_show && r_act_dp[r_idx]);
   end

   // Output register keeps the pins glitch-free and free of input-to-output paths
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seg_n       <= SEG_BLANK;
         dp_n        <= 1'b1;
         digit_sel   <= '0;
         frame_start <= 1'b0;
      end else begin
         seg_n       <= w_seg_n_nxt;
         dp_n        <= w_dp_n_nxt;
         digit_sel   <= w_sel_nxt;
         frame_start <= w_frame_entry;
      end
   end

endmodule

// File: tb/tb_sevseg_scan_scheduler.sv
// tb_sevseg_scan_scheduler: scoreboard bench for the blanked, tear-free 7-segment scanner
module tb_sevseg_scan_scheduler;

   typedef struct {
      logic [3:0] sel;
      logic [6:0] seg;
      logic       dp_n;
      int         gap;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] wr_data = '0;
   logic [3:0]  wr_dp = '0;
   logic        wr_valid = 1'b0;
   logic        wr_ready;
   logic [3:0]  digit_en = 4'hF;
   logic [6:0]  seg_n;
   logic        dp_n;
   logic [3:0]  digit_sel;
   logic        frame_start;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int n_fs;
   int stall1, stall2;
   exp_t q[$];

   // Active-low glyphs for 0..F
   logic [6:0] glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

   sevseg_scan_scheduler #(.DIGITS(4), .SCAN_DIV(8), .BLANK_CYCLES(2)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .wr_data     (wr_data),
      .wr_dp       (wr_dp),
      .wr_valid    (wr_valid),
      .wr_ready    (wr_ready),
      .digit_en    (digit_en),
      .seg_n       (seg_n),
      .dp_n        (dp_n),
      .digit_sel   (digit_sel),
      .frame_start (frame_start)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Expected shows for one frame; gap = dark cycles since the previous enabled slot
   task automatic push_frame(input logic [15:0] d, input logic [3:0] p, input logic [3:0] en);
      exp_t e;
      int   last = -1;
      for (int i = 0; i < 4; i++) begin
         if (en[i]) begin
            e.sel  = 4'(1 << i);
            e.seg  = glyph[d[4*i +: 4]];
            e.dp_n = ~p[i];
            e.gap  = (last < 0) ? 0 : 2 + 8 * (i - last - 1);
            q.push_back(e);
            last = i;
         end
      end
   endtask

   task automatic wait_fs(output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!frame_start && n < 40);
      if (!frame_start) begin
         checks++;
         errors++;
         $display("FAIL fs_timeout: got no frame_start within %0d cycles required one", n);
      end
   endtask

   task automatic write(input logic [15:0] d, input logic [3:0] p, output int stall);
      stall = 0;
      wr_data = d;
      wr_dp = p;
      wr_valid = 1'b1;
      while (!wr_ready && stall < 100) begin
         @(negedge clk);
         stall++;
      end
      if (!wr_ready) begin
         checks++;
         errors++;
         $display("FAIL wr_timeout: got wr_ready=0 for %0d cycles required 1", stall);
      end
      @(negedge clk);
      wr_valid = 1'b0;
   endtask

   // Monitor: pops one expectation per show window and checks slot/frame timing
   int   mon_prev = 0;
   int   mon_run = 0;
   int   mon_gap = 0;
   int   fs_cyc = 0;
   bit   have_fs = 0;
   exp_t cur;
   always @(negedge clk) begin
      if (!rst_n) begin
         mon_prev = 0;
         mon_run = 0;
         mon_gap = 0;
         have_fs = 0;
      end else begin
         if (frame_start) begin
            if (have_fs) chk("fs_period", 32'(cyc - fs_cyc), 32);
            fs_cyc = cyc;
            have_fs = 1;
         end
         if (digit_sel != 4'b0) begin
            if (mon_prev == 0) begin
               checks++;
               if (q.size() == 0) begin
                  errors++;
                  $display("FAIL unexpected_show: got sel=%b required no show", digit_sel);
               end else begin
                  cur = q.pop_front();
                  chk("show_sel", 32'(digit_sel), 32'(cur.sel));
                  chk("show_seg", 32'(seg_n), 32'(cur.seg));
                  chk("show_dp", 32'(dp_n), 32'(cur.dp_n));
                  if (cur.gap != 0) chk("dark_gap", 32'(mon_gap), 32'(cur.gap));
                  if (cur.sel == 4'b0001 && have_fs) chk("fs_to_slot0", 32'(cyc - fs_cyc), 2);
               end
               mon_run = 0;
            end else if (digit_sel != 4'(mon_prev)) begin
               chk("sel_stable", 32'(digit_sel), 32'(mon_prev));
            end
            mon_run++;
         end else begin
            if (mon_prev != 0) begin
               chk("show_len", 32'(mon_run), 6);
               mon_gap = 0;
            end
            mon_gap++;
            chk("blank_seg", 32'(seg_n), 32'h7F);
            chk("blank_dp", 32'(dp_n), 1);
         end
         mon_prev = int'(digit_sel);
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: got no end of test required finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_seg", 32'(seg_n), 32'h7F);
      chk("rst_dp", 32'(dp_n), 1);
      chk("rst_sel", 32'(digit_sel), 0);
      chk("rst_fs", 32'(frame_start), 0);
      chk("rst_ready", 32'(wr_ready), 1);
      #1 rst_n = 1'b1;
      wait_fs(n_fs);
      chk("first_fs_delay", 32'(n_fs), 1);
      push_frame(16'h0000, 4'h0, 4'hF);
      // Single write commits at the next frame
      write(16'h1A2F, 4'b0001, stall1);
      chk("write1_stall", 32'(stall1), 0);
      wait_fs(n_fs);
      push_frame(16'h1A2F, 4'b0001, 4'hF);
      // Back-to-back writes: the second one waits for the commit
      fork
         begin
            write(16'h1111, 4'h0, stall1);
            write(16'h2222, 4'h0, stall2);
         end
         begin
            wait_fs(n_fs);
            push_frame(16'h1111, 4'h0, 4'hF);
            wait_fs(n_fs);
         end
      join
      chk("b2b_first_stall", 32'(stall1), 0);
      chk("b2b_second_stall", 32'(stall2), 31);
      // Masking of digits 1 and 3
      digit_en = 4'b0101;
      push_frame(16'h2222, 4'h0, 4'b0101);
      wait_fs(n_fs);
      push_frame(16'h2222, 4'h0, 4'b0101);
      wait_fs(n_fs);
      digit_en = 4'hF;
      push_frame(16'h2222, 4'h0, 4'hF);
      // Tear-free: write lands during the slot-2 show, frame keeps old data
      repeat (19) @(negedge clk);
      chk("mid_slot2_sel", 32'(digit_sel), 32'b0100);
      write(16'h4B7D, 4'b1010, stall1);
      chk("tear_stall", 32'(stall1), 0);
      wait_fs(n_fs);
      push_frame(16'h4B7D, 4'b1010, 4'hF);
      // Reset during a show with a write pending
      write(16'h9999, 4'hF, stall1);
      repeat (3) @(negedge clk);
      chk("pre_rst_sel", 32'(digit_sel), 32'b0001);
      chk("pre_rst_ready", 32'(wr_ready), 0);
      #1 rst_n = 1'b0;
      q.delete();
      #1;
      chk("mid_rst_seg", 32'(seg_n), 32'h7F);
      chk("mid_rst_sel", 32'(digit_sel), 0);
      chk("mid_rst_dp", 32'(dp_n), 1);
      chk("mid_rst_ready", 32'(wr_ready), 1);
      repeat (2) @(negedge clk);
      #1 rst_n = 1'b1;
      wait_fs(n_fs);
      chk("rerst_fs_delay", 32'(n_fs), 1);
      push_frame(16'h0000, 4'h0, 4'hF);
      wait_fs(n_fs);
      push_frame(16'h0000, 4'h0, 4'hF);
      repeat (30) @(negedge clk);
      chk("queue_drained", 32'(q.size()), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
